// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // At least one bit so a consumer ID is always a real vector.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Wide enough to hold MAX_BURST itself, so the counter saturates instead of wrapping.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: search starts at last_id+1 and wraps modulo NUM_REQ.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_id,
    output logic [NUM_REQ-1:0] win,
    output logic [IDW-1:0]     win_id,
    output logic               any
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_id) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win_id   = idx;
                win[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares the async FIFO read port among NUM_REQ consumers in round-robin bursts
// of up to MAX_BURST pops; popped words come back registered and tagged with the owner.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    localparam int IDW       = id_width(NUM_REQ),
    localparam int CW        = cnt_width(MAX_BURST)
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  burst_done,
    output logic [CW-1:0]         burst_len,
    output logic                  busy,
    output state_e                dbg_state_o
);

    state_e                state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [IDW-1:0]        last_id_q, last_id_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]        out_id_q, out_id_d;
    logic                  burst_done_q, burst_done_d;
    logic [CW-1:0]         burst_len_q, burst_len_d;

    logic [NUM_REQ-1:0]    arb_win;
    logic [IDW-1:0]        arb_id;
    logic                  arb_any;
    logic                  pop;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req     (req),
        .last_id (last_id_q),
        .win     (arb_win),
        .win_id  (arb_id),
        .any     (arb_any)
    );

    // In BURST every cycle either pops or closes: the close conditions are exactly !pop.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_id_d    = last_id_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        burst_done_d = 1'b0;
        burst_len_d  = burst_len_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any && !empty) begin
                    state_d = BURST;
                    owner_d = arb_id;
                    cnt_d   = '0;
                    gnt_d   = arb_win;
                end
            end
            BURST: begin
                if (req[owner_q] && !empty && (cnt_q < CW'(MAX_BURST))) begin
                    pop         = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                    out_valid_d = 1'b1;
                    out_data_d  = r_data;
                    out_id_d    = owner_q;
                end else begin
                    state_d      = IDLE;
                    last_id_d    = owner_q;
                    gnt_d        = '0;
                    burst_done_d = 1'b1;
                    burst_len_d  = cnt_q;
                end
            end
        endcase
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_id_q    <= IDW'(NUM_REQ - 1);
            cnt_q        <= '0;
            gnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            burst_done_q <= 1'b0;
            burst_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_id_q    <= last_id_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            burst_done_q <= burst_done_d;
            burst_len_q  <= burst_len_d;
        end
    end

    assign r_en        = pop;
    assign gnt         = gnt_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign burst_done  = burst_done_q;
    assign burst_len   = burst_len_q;
    assign busy        = (state_q == BURST);
    assign dbg_state_o = state_q;

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-domain controller that shares the async FIFO's single read port among NUM_REQ consumers. It arbitrates round-robin, grants bursts of up to MAX_BURST pops to one consumer, and drives the FIFO `r_en`. Popped words are returned registered and tagged with the owner's ID. It sits in the `r_clk` domain between the FIFO read-pointer/empty logic and the downstream consumers.

## Interface
- NUM_REQ, 4: number of consumers (≥2)
- DATA_WIDTH, 8: FIFO word width
- MAX_BURST, 8: maximum pops per grant (≥1)
- r_clk  in  1  read-domain clock, single clock for the block
- rrst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-consumer read request (level)
- empty  in  1  FIFO empty flag (registered, from read-pointer logic)
- r_data  in  DATA_WIDTH  FIFO word at current read pointer (valid while !empty)
- r_en  out  1  FIFO pop strobe
- gnt  out  NUM_REQ  one-hot current owner, all-zero when idle
- out_valid  out  1  registered: word popped last cycle
- out_data  out  DATA_WIDTH  popped word
- out_id  out  $clog2(NUM_REQ)  owner of out_data
- burst_done  out  1  one-cycle pulse when a burst closes
- burst_len  out  $clog2(MAX_BURST+1)  pops in closed burst (valid with burst_done)
- busy  out  1  high in BURST state

## Operation
- FSM states: IDLE, BURST.
- IDLE: if `|req && !empty`, select the winner by rotating priority, starting at `last_id+1` and wrapping modulo NUM_REQ. Register `owner` and clear `cnt`, then go to BURST. Otherwise stay in IDLE. `r_en=0` in IDLE.
- BURST: `gnt[owner]=1`. `r_en = req[owner] & !empty & (cnt < MAX_BURST)`. Each pop increments `cnt` and registers `out_data=r_data`, `out_id=owner`, `out_valid=1`.
- The burst closes when the first of these occurs in a BURST cycle:
  - `req[owner]==0`, or
  - `empty==1`, or
  - `cnt==MAX_BURST`.
- In that closing cycle `r_en=0`. Next cycle the block is back in IDLE, with `last_id=owner`, `burst_done=1` and `burst_len=cnt`.
- A burst may close with `burst_len=0` if req drops or empty rises before the first pop. `burst_done` still pulses.
- Only the owner is ever popped for. Requests from other consumers during a burst wait for IDLE.
- `out_valid` is high exactly one cycle per pop, with no gaps introduced by the block.
- Never pop while `empty=1`. This protects the pointer logic against underflow.
- Counter width is `$clog2(MAX_BURST+1)`. It is compared against MAX_BURST and saturates, never wraps.

## Timing
- Reset (async assert, sync release): state=IDLE, `last_id=NUM_REQ-1` (so consumer 0 wins first), `owner=0`, `cnt=0`. All outputs are 0: `r_en`, `gnt`, `out_valid`, `out_data`, `out_id`, `burst_done`, `burst_len`, `busy`.
- Reset mid-burst aborts immediately with no `burst_done`. Words already popped are lost by design.
- Grant latency: req and !empty sampled at edge N puts BURST/`gnt` in cycle N+1. First `r_en` is in cycle N+1, first `out_valid` in cycle N+2.
- A full burst of length L occupies L+1 BURST cycles (the last one is the closing cycle), then one IDLE arbitration cycle. Back-to-back grant gap is therefore 2 cycles of `r_en=0`.
- `r_en` is combinational from state/cnt/req/empty. All other outputs are registered.
- Simultaneous req rise and empty fall in the same cycle: arbitration sees both at the next edge.

## Structure
- Package `fifo_arb_pkg`: state enum {IDLE, BURST}, and helper functions for the ID and count widths.
- Sub-module `rr_arbiter`: combinational rotating-priority pick over NUM_REQ. Inputs are `req` and `last_id`; outputs are one-hot `win` and `win_id`, plus `any`.
- Top holds the FSM, counter, owner/last_id registers and output pipeline register.

## Test plan
- Reset, then `req=4'b0001` with FIFO holding 3 words → `gnt=0001` one cycle after req. Three `r_en` pulses, `out_data` = words 0..2 with `out_id=0`. Empty closes the burst; `burst_done` with `burst_len=3`.
- All four req high, FIFO holding 40 words, MAX_BURST=8 → grant order 0,1,2,3,0, each `burst_len=8`, with a 2-cycle `r_en` gap between bursts.
- Owner drops req after 2 pops → burst closes, `burst_len=2`, and the next requester in rotation is granted.
- req high with `empty=1` → block stays in IDLE with `r_en` never asserted. When empty falls, grant follows 1 cycle later.
- Empty rises before the first pop in BURST → `burst_done` with `burst_len=0`, and no `out_valid`.
- Assert rrst_n low mid-burst → all outputs 0 immediately. After release, consumer 0 has first priority.
